// File: rtl/fdiv_pkg.sv
// Shared constants and helpers for the parametrised frequency divider.
// Optional feature macro: FDIV_RESTART_EN (per-channel restart input).
package fdiv_pkg;
   localparam int DEF_CLK_HZ  = 50_000_000;
   localparam int DEF_BASE_HZ = 128;

   localparam int DIV_1HZ = 64;
   localparam int DIV_AUX = 32;
   localparam int DIV_BTN = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/fdiv_channel.sv
// One divider channel: shadow divisor, base-tick counter, tick and square flops.
// Optional feature macro: FDIV_RESTART_EN (drives restart_i from the top).
module fdiv_channel
   import fdiv_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sclr_i,
   input  logic             stb_i,
   input  logic             restart_i,
   input  logic [CNT_W-1:0] div_i,
   output logic             tick_o,
   output logic             sq_o
);
   logic [CNT_W-1:0] sdiv_q, sdiv_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   always_comb begin
      sdiv_d = sdiv_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sclr_i || restart_i || (sdiv_q == '0)) begin
         // An idle channel keeps sampling its divisor so a new ratio starts at once.
         sdiv_d = div_i;
         cnt_d  = '0;
         sq_d   = 1'b0;
      end else if (stb_i) begin
         if (cnt_q == sdiv_q - CNT_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            sdiv_d = div_i;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sdiv_q <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         sdiv_q <= sdiv_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;
endmodule

// File: rtl/freq_divider_param.sv
// Prescaler to BASE_HZ plus N_CH programmable divider channels (enables, not clocks).
// Optional feature macro: FDIV_RESTART_EN adds the ch_restart input.
module freq_divider_param
   import fdiv_pkg::*;
#(
   parameter int CLK_HZ  = DEF_CLK_HZ,
   parameter int BASE_HZ = DEF_BASE_HZ,
   parameter int N_CH    = 3,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  sclr,
   input  logic [N_CH*CNT_W-1:0] ch_div,
   output logic                  base_tick,
   output logic [N_CH-1:0]       ch_tick,
   output logic [N_CH-1:0]       ch_sq
`ifdef FDIV_RESTART_EN
   ,
   input  logic [N_CH-1:0]       ch_restart
`endif
);
   localparam int PRE_DIV = CLK_HZ / BASE_HZ;
   localparam int PRE_W   = clog2(PRE_DIV);

   generate
      if ((CLK_HZ % BASE_HZ) != 0) begin : g_err_ratio
         $error("CLK_HZ must be an integer multiple of BASE_HZ");
      end
      if (PRE_DIV < 2) begin : g_err_pre
         $error("PRE_DIV must be at least 2");
      end
      if (N_CH < 1) begin : g_err_nch
         $error("N_CH must be at least 1");
      end
      if (CNT_W < 1) begin : g_err_cntw
         $error("CNT_W must be at least 1");
      end
   endgenerate

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             base_q, base_d;
   logic             stb;
   logic [N_CH-1:0]  restart;

`ifdef FDIV_RESTART_EN
   assign restart = ch_restart;
`else
   assign restart = '0;
`endif

   // Channels act on the wrap strobe itself so their outputs land with base_tick.
   assign stb = en && (pre_q == PRE_W'(PRE_DIV - 1));

   always_comb begin
      pre_d  = pre_q;
      base_d = 1'b0;
      if (sclr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d  = stb ? '0 : pre_q + PRE_W'(1);
         base_d = stb;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         base_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         base_q <= base_d;
      end
   end

   assign base_tick = base_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      fdiv_channel #(.CNT_W(CNT_W)) u_ch (
         .clk_i     (clk),
         .rst_ni    (reset),
         .sclr_i    (sclr),
         .stb_i     (stb),
         .restart_i (restart[i]),
         .div_i     (ch_div[i*CNT_W +: CNT_W]),
         .tick_o    (ch_tick[i]),
         .sq_o      (ch_sq[i])
      );
   end
endmodule

// File: tb/tb_freq_divider_param.sv
// Bench for freq_divider_param: period/phase model plus pinned edge expectations.
module tb_freq_divider_param;
   localparam int CLK_HZ = 16, BASE_HZ = 4, N_CH = 3, CNT_W = 4;
   localparam int PRE = CLK_HZ / BASE_HZ;

   logic clk = 1'b0, reset = 1'b0, en = 1'b0, sclr = 1'b0;
   logic [N_CH*CNT_W-1:0] ch_div = {4'd3, 4'd2, 4'd1};
   logic [N_CH-1:0] restart = '0;
   logic base_tick;
   logic [N_CH-1:0] ch_tick, ch_sq;

   int vec = 0, err = 0, cyc = 0;

   freq_divider_param #(.CLK_HZ(CLK_HZ), .BASE_HZ(BASE_HZ), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sclr      (sclr),
      .ch_div    (ch_div),
      .base_tick (base_tick),
      .ch_tick   (ch_tick),
      .ch_sq     (ch_sq)
`ifdef FDIV_RESTART_EN
      ,
      .ch_restart(restart)
`endif
   );

   always #5 clk = ~clk;

   // Model: prescaler phase = enabled edges mod PRE; channel = base ticks into current period.
   int ph, per[N_CH], pos[N_CH];
   bit mbt;
   bit [N_CH-1:0] mtk, msq;

   always @(posedge clk) begin
      bit stb;
      if (!reset) begin
         cyc = 0; ph = 0; mbt = 0; mtk = '0; msq = '0;
         for (int i = 0; i < N_CH; i++) begin per[i] = 0; pos[i] = 0; end
      end else begin
         cyc++;
         mtk = '0;
         if (sclr) begin
            ph = 0; mbt = 0; msq = '0;
            for (int i = 0; i < N_CH; i++) begin per[i] = int'(ch_div[i*CNT_W +: CNT_W]); pos[i] = 0; end
         end else begin
            stb = 0;
            if (en) begin ph = (ph + 1) % PRE; stb = (ph == 0); end
            mbt = stb;
            for (int i = 0; i < N_CH; i++) begin
               if (restart[i] || per[i] == 0) begin
                  per[i] = int'(ch_div[i*CNT_W +: CNT_W]); pos[i] = 0; msq[i] = 0;
               end else if (stb) begin
                  pos[i]++;
                  if (pos[i] == per[i]) begin
                     pos[i] = 0; mtk[i] = 1; msq[i] = ~msq[i];
                     per[i] = int'(ch_div[i*CNT_W +: CNT_W]);
                  end
               end
            end
         end
      end
      #1;
      vec++;
      if ({base_tick, ch_tick, ch_sq} !== {mbt, mtk, msq}) begin
         err++;
         $display("FAIL model cyc=%0d: dut bt/tk/sq=%b/%b/%b expected %b/%b/%b",
                  cyc, base_tick, ch_tick, ch_sq, mbt, mtk, msq);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Returns at the negedge following posedge n (counted from reset release).
   task automatic wait_edge(input int n);
      int guard = 0;
      while (cyc < n && guard < 5000) begin @(negedge clk); guard++; end
      if (cyc < n) begin
         $display("FAIL wait_edge: reached %0d expected %0d", cyc, n);
         err++;
      end
   endtask

   initial begin
      int e;
      repeat (2) @(negedge clk);
      chk("reset_outputs", int'({base_tick, ch_tick, ch_sq}), 0);
      reset = 1'b1; en = 1'b1;

      wait_edge(3);  chk("bt@3", base_tick, 0);
      wait_edge(4);  chk("bt@4", base_tick, 1); chk("tk0@4", ch_tick[0], 1); chk("tk1@4", ch_tick[1], 0);
      wait_edge(5);  chk("bt@5", base_tick, 0);
      wait_edge(8);  chk("sq0@8", ch_sq[0], 0); chk("tk1@8", ch_tick[1], 1); chk("tk2@8", ch_tick[2], 0);
      wait_edge(11); chk("sq2@11", ch_sq[2], 0);
      wait_edge(12); chk("tk2@12", ch_tick[2], 1); chk("sq2@12", ch_sq[2], 1);
      wait_edge(16); chk("sq1@16", ch_sq[1], 0);

      wait_edge(28); ch_div[8 +: 4] = 4'd5;
      wait_edge(36); chk("tk2@36", ch_tick[2], 1);
      wait_edge(48); chk("tk2@48", ch_tick[2], 0);
      wait_edge(56); chk("tk2@56", ch_tick[2], 1);

      wait_edge(60); ch_div[4 +: 4] = 4'd0;
      wait_edge(64); chk("tk1@64", ch_tick[1], 1);
      wait_edge(72); chk("tk1@72", ch_tick[1], 0); chk("sq1@72", ch_sq[1], 0);
      wait_edge(84); ch_div[4 +: 4] = 4'd2;
      wait_edge(88); chk("tk1@88", ch_tick[1], 0);
      wait_edge(92); chk("tk1@92", ch_tick[1], 1);

      wait_edge(97);  en = 1'b0;
      wait_edge(100); chk("bt@100_en0", base_tick, 0);
      wait_edge(107); en = 1'b1;
      wait_edge(109); chk("bt@109", base_tick, 0);
      wait_edge(110); chk("bt@110", base_tick, 1);

      @(negedge clk); sclr = 1'b1;
      @(negedge clk); sclr = 1'b0; e = cyc;
      chk("sclr_outputs", int'({base_tick, ch_tick, ch_sq}), 0);
      wait_edge(e + 3); chk("bt_after_sclr-1", base_tick, 0);
      wait_edge(e + 4); chk("bt_after_sclr", base_tick, 1);

      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         en   = ($urandom_range(0, 9) != 0);
         sclr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 29) == 0) ch_div[$urandom_range(0, N_CH-1)*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
`ifdef FDIV_RESTART_EN
         restart = ($urandom_range(0, 49) == 0) ? N_CH'(1 << $urandom_range(0, N_CH-1)) : '0;
`endif
      end
      @(negedge clk); en = 1'b1; sclr = 1'b0; restart = '0;
      ch_div = {4'd3, 4'd2, 4'd1};
      wait_edge(cyc + 20);

      #2 reset = 1'b0;
      #1 chk("async_reset_outputs", int'({base_tick, ch_tick, ch_sq}), 0);
      ch_div = {4'd3, 4'd2, 4'd3};
      @(negedge clk); reset = 1'b1;
`ifdef FDIV_RESTART_EN
      wait_edge(8);  restart = 3'b001;
      @(negedge clk); restart = '0;
      chk("rst_sq0@9", ch_sq[0], 0);
      wait_edge(12); chk("rst_tk0@12", ch_tick[0], 0); chk("rst_tk2@12", ch_tick[2], 1);
      wait_edge(16); chk("rst_tk1@16", ch_tick[1], 1);
      wait_edge(20); chk("rst_tk0@20", ch_tick[0], 1);
`else
      wait_edge(12); chk("tk0@12_div3", ch_tick[0], 1); chk("tk2@12_div3", ch_tick[2], 1);
      wait_edge(16); chk("tk1@16", ch_tick[1], 1);
`endif
      wait_edge(cyc + 4);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/freq_divider_param.md
Name: freq_divider_param

Overview:
Parametrised, fully synchronous successor to the fixed 50 MHz-to-1 Hz ripple divider chain. One prescaler produces a base tick at BASE_HZ. N_CH independent channels divide that base tick by runtime-programmable ratios. Each channel emits a one-clk tick (clock enable) and a 50 % square wave. Elevator timing (1 Hz main, auxiliary, button scan) consumes the tick outputs as enables, not as clocks.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz.
BASE_HZ, 128, prescaler output rate. PRE_DIV = CLK_HZ/BASE_HZ.
N_CH, 3, number of divider channels.
CNT_W, 8, width of each channel divisor and counter.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
en  in  1  global count enable; low freezes all counters.
sclr  in  1  synchronous clear of all counters and outputs.
ch_div  in  N_CH*CNT_W  per-channel divisor in base ticks; channel i uses bits [i*CNT_W +: CNT_W]; 0 = channel off.
base_tick  out  1  one-clk pulse at BASE_HZ.
ch_tick  out  N_CH  one-clk pulse per channel at BASE_HZ/div.
ch_sq  out  N_CH  square wave per channel at BASE_HZ/(2*div).

Behaviour:
- Elaboration error if CLK_HZ % BASE_HZ != 0, PRE_DIV < 2, N_CH < 1, or CNT_W < 1.
- Reset (reset=0, asynchronous): prescaler count=0, all channel counts=0, shadow divisors=0, base_tick=0, ch_tick=0, ch_sq=0.
- Prescaler: counts 0..PRE_DIV-1 on each clk with en=1. On the wrap edge, registered base_tick=1 for exactly one clk. The first base_tick goes high on the PRE_DIV-th enabled edge after reset.
- Channel i holds shadow divisor sdiv. sdiv loads from ch_div[i] in three cases:
  - immediately, when sdiv==0;
  - on sclr;
  - at terminal count, i.e. a base_tick with count==sdiv-1.
  A divisor change therefore never shortens or truncates a running period.
- Channel count: on base_tick with sdiv!=0, count increments. At count==sdiv-1 it wraps to 0, ch_tick[i]=1 for one clk, and ch_sq[i] toggles.
- Latency: ch_tick and the ch_sq edge appear on the same clk edge as the corresponding base_tick. All three are registered on the same edge, with no added delay.
- Divisor 1: ch_tick coincides with every base_tick; ch_sq toggles every base_tick.
- sdiv==0: count held at 0, ch_tick=0, ch_sq=0.
- en=0: prescaler and channels frozen, base_tick and ch_tick forced 0, ch_sq holds its value. Resuming continues from the frozen counts.
- sclr=1: has priority over en. All counts=0, ticks=0, ch_sq=0, and every sdiv reloads from ch_div.
- Reset asserted mid-period: immediate return to the reset state, with no partial pulse on any output.
- All outputs are driven directly from flops (glitch-free).

Optional Feature:
FDIV_RESTART_EN defined:
- Adds input ch_restart [N_CH].
- ch_restart[i]=1 synchronously sets channel i count=0 and ch_sq[i]=0, and reloads sdiv. ch_tick[i] is suppressed that cycle.
- Other channels and the prescaler are unaffected.
- Use: re-phase the door-open timer on a button press.
- sclr has priority over ch_restart.
FDIV_RESTART_EN not defined: the port is absent and channels are re-phased only by sclr or reset.

Decomposition:
- Package fdiv_pkg holds:
  - DEF_CLK_HZ=50_000_000 and DEF_BASE_HZ=128;
  - elevator divisor constants DIV_1HZ=64, DIV_AUX=32, DIV_BTN=4;
  - a clog2 function for the prescaler width.
- Sub-module fdiv_channel contains one channel: shadow divisor, counter, tick and square flops, and the restart logic. The top level instantiates it N_CH times in a generate loop next to the prescaler.

Test Plan:
- Bench parameters CLK_HZ=16, BASE_HZ=4 (PRE_DIV=4), N_CH=3, CNT_W=4, with ch_div={3,2,1} and en=1 after reset release:
  - base_tick high on edges 4, 8, 12, …
  - ch_tick[0] every 4 clk; ch_tick[1] every 8 clk; ch_tick[2] every 12 clk.
  - ch_sq[0] period 8 clk; ch_sq[1] period 16 clk; ch_sq[2] period 24 clk.
- Divisor change mid-period: ch_div[2] goes 3→5 when count[2]=1. The current period completes at 3 base ticks; following ticks are spaced 5 base ticks (20 clk).
- Channel off: ch_div[1]=0 → ch_tick[1] and ch_sq[1] stay 0. Setting ch_div[1]=2 gives the first ch_tick[1] 2 base ticks later.
- en low for 10 clk mid-count: no base_tick or ch_tick while low, ch_sq held. The next base_tick arrives exactly the remaining count after en rises.
- sclr and reset: sclr=1 together with en=1 clears all outputs on the next edge, and counting restarts from 0. Asserting reset between edges drives every output to 0 immediately.
- FDIV_RESTART_EN defined: a ch_restart[0] pulse at count[0]=2 gives ch_sq[0]=0 and a next ch_tick[0] 3 base ticks later. ch_tick[1] and ch_tick[2] timing is unchanged.
